// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: branch-select encodings.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    BS_SEQ  = 2'd0,
    BS_COND = 2'd1,
    BS_REG  = 2'd2,
    BS_JMP  = 2'd3
  } bs_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry; a pop while empty only raises the sticky underflow flag.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] sp;          // next free slot; the oldest entry once full
  logic          full;
  logic          empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign top   = mem[PW'(sp - 1'b1)];

  // Pointer, occupancy and sticky error flags.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp    <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else if (push) begin
      sp <= PW'(sp + 1'b1);
      if (full) ovf   <= 1'b1;
      else      count <= CW'(count + 1'b1);
    end else if (pop) begin
      if (empty) begin
        unf <= 1'b1;
      end else begin
        sp    <= PW'(sp - 1'b1);
        count <= CW'(count - 1'b1);
      end
    end
  end

  // Entry storage written at the current pointer on every push.
  // NOTE: the array has no reset; count and sp are reset, so stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection: exception redirect, stall hold,
// sequential, conditional, register and unconditional transfers, with
// call/return prediction through the pc_ras stack.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              ADDR_W    = 32,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(16'h0004)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stall,
  input  logic                        exc,
  input  logic [1:0]                  bs,
  input  logic                        ps,
  input  logic                        z,
  input  logic                        link,
  input  logic                        ret,
  input  logic [ADDR_W-1:0]           br_a,
  input  logic [ADDR_W-1:0]           ra_a,
  output logic [PC_W-1:0]             pc,
  output logic [PC_W-1:0]             npc,
  output logic                        taken,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        ras_ovf,
  output logic                        ras_unf
);

  logic [PC_W-1:0] next_pc;
  logic [PC_W-1:0] ras_top;
  logic            push;
  logic            pop;
  logic            ras_empty;

  assign npc       = PC_W'(pc + 1'b1);
  assign ras_empty = (ras_count == '0);

  // Next-PC selection with priority exc > stall > branch select.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_pc = pc;
    taken   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    if (exc) begin
      next_pc = EXC_VEC;
      taken   = 1'b1;
    end else if (!stall) begin
      unique case (bs_e'(bs))
        BS_SEQ: next_pc = npc;
        BS_COND: begin
          if (ps ^ z) begin
            next_pc = br_a[PC_W-1:0];
            taken   = 1'b1;
            push    = link;
          end else begin
            next_pc = npc;
          end
        end
        BS_REG: begin
          taken = 1'b1;
          // ret on an empty stack still reaches pc_ras so it can flag underflow
          pop   = ret;
          if (ret && !ras_empty) next_pc = ras_top;
          else                   next_pc = ra_a[PC_W-1:0];
        end
        BS_JMP: begin
          next_pc = br_a[PC_W-1:0];
          taken   = 1'b1;
          push    = link;
        end
        default: next_pc = npc;
      endcase
    end
  end

  // Program-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (npc),
    .top       (ras_top),
    .count     (ras_count),
    .ovf       (ras_ovf),
    .unf       (ras_unf)
  );

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL provide parameter PC_W, default 16: program-counter width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 32: width of branch/register target inputs.
REQ-003 SHALL provide parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, >= 2.
REQ-004 SHALL provide parameter RESET_PC, default 0: PC value after reset.
REQ-005 SHALL provide parameter EXC_VEC, default 16'h0004: exception redirect address.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 stall  input  1  hold PC and stack this cycle.
REQ-009 exc  input  1  redirect to EXC_VEC; overrides stall and bs.
REQ-010 bs  input  2  branch select: 0 sequential, 1 conditional, 2 register jump, 3 unconditional.
REQ-011 ps  input  1  conditional branch polarity.
REQ-012 z  input  1  zero flag.
REQ-013 link  input  1  push return address when a bs=1 or bs=3 transfer is taken.
REQ-014 ret  input  1  with bs=2, take target from stack top and pop.
REQ-015 br_a  input  ADDR_W  branch target for bs=1 and bs=3.
REQ-016 ra_a  input  ADDR_W  register target for bs=2.
REQ-017 pc  output  PC_W  registered current PC.
REQ-018 npc  output  PC_W  combinational pc+1, wrapping mod 2^PC_W.
REQ-019 taken  output  1  combinational; high when the next PC is not npc (exc or taken transfer), low while stall without exc.
REQ-020 ras_count  output  clog2(RAS_DEPTH)+1  registered valid-entry count.
REQ-021 ras_ovf  output  1  sticky: push occurred while full.
REQ-022 ras_unf  output  1  sticky: ret occurred while empty.

Function
REQ-023 Priority SHALL be exc > stall > bs.
REQ-024 exc=1: next pc = EXC_VEC; stack unchanged; taken=1.
REQ-025 stall=1, exc=0: pc, stack, count and flags hold.
REQ-026 bs=0: next pc = npc.
REQ-027 bs=1: taken iff ps XOR z; taken -> br_a[PC_W-1:0], else npc.
REQ-028 bs=3: next pc = br_a[PC_W-1:0].
REQ-029 bs=2, ret=0: next pc = ra_a[PC_W-1:0].
REQ-030 bs=2, ret=1, stack non-empty: next pc = stack top; pop; count-1.
REQ-031 bs=2, ret=1, stack empty: next pc = ra_a[PC_W-1:0]; no pop; ras_unf set.
REQ-032 link=1 with taken bs=1/bs=3: push npc; count+1 if not full.
REQ-033 Push while full: overwrite oldest entry (circular), count stays RAS_DEPTH, ras_ovf set.
REQ-034 link ignored for bs=0, bs=2, untaken bs=1; ret ignored unless bs=2; push and pop never coincide.
REQ-035 Latency: every redirect visible on pc one cycle after the deciding edge.
REQ-036 Targets wider than PC_W SHALL be truncated to low PC_W bits; no range error.

Reset
REQ-037 rst_n low SHALL immediately force pc=RESET_PC, ras_count=0, ras_ovf=0, ras_unf=0, stack pointer=0, regardless of clk.
REQ-038 Reset mid-operation SHALL discard all stack contents; sticky flags clear only on reset.
REQ-039 First update after rst_n rises occurs on the next rising clk edge.

Structure
REQ-040 Shared package pc_unit_pkg SHALL hold bs encodings BS_SEQ=0, BS_COND=1, BS_REG=2, BS_JMP=3.
REQ-041 Stack SHALL be sub-module pc_ras (push, pop, top, count, ovf, unf); pc_unit holds PC register and next-PC selection.

Verification
REQ-042 Reset, then bs=0 for 3 cycles -> pc 0,1,2,3; taken=0.
REQ-043 bs=1, ps=0, z=1, br_a=32'h0040 -> taken=1, pc=16'h0040 next cycle; ps=1, z=1 -> pc=npc.
REQ-044 pc=16'h0010, bs=3, link=1, br_a=16'h0100, then bs=2, ret=1, ra_a=16'h0777 -> pc 16'h0100, then 16'h0011; ras_count 1 then 0.
REQ-045 Five linked calls with RAS_DEPTH=4 -> ras_count=4, ras_ovf=1; four rets return last four return addresses newest first; fifth ret uses ra_a, ras_unf=1.
REQ-046 stall=1 with bs=3 -> pc holds; stall=1 and exc=1 together -> pc=EXC_VEC, ras_count unchanged.
REQ-047 pc=16'hFFFF, bs=0 -> pc=16'h0000; rst_n low mid-cycle -> pc=RESET_PC immediately, count and flags 0.
